// File: rtl/addsub_pack_pkg.sv
// Shared types and helpers for the add/sub packing serializer.
package addsub_pack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int unsigned STAT_CARRY  = 0;
  localparam int unsigned STAT_BORROW = 1;
  localparam int unsigned STAT_TRUNC  = 2;
  localparam int unsigned STAT_W      = 3;

  function automatic int unsigned calc_nbeats(input int unsigned pack_w,
                                              input int unsigned beat_w);
    return (pack_w + beat_w - 1) / beat_w;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational truncated sum/difference and packing; optional status flags
// when ADDSUB_STATUS_BEAT_EN is defined.
module addsub_core
  import addsub_pack_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 8,
  parameter int unsigned DIFF_W = 4
) (
  input  logic [DATA_W-1:0]        i_a,
  input  logic [DATA_W-1:0]        i_b,
`ifdef ADDSUB_STATUS_BEAT_EN
  output logic [STAT_W-1:0]        o_flags,
`endif
  output logic [DIFF_W+SUM_W-1:0]  o_packed
);

  // One guard bit above the widest field keeps the full sum and signed diff exact.
  localparam int unsigned EXT_W = max3(DATA_W, SUM_W, DIFF_W) + 1;

  logic [EXT_W-1:0] w_a_ext;
  logic [EXT_W-1:0] w_b_ext;

  assign w_a_ext  = EXT_W'(i_a);
  assign w_b_ext  = EXT_W'(i_b);
  assign o_packed = {DIFF_W'(w_a_ext - w_b_ext), SUM_W'(w_a_ext + w_b_ext)};

`ifdef ADDSUB_STATUS_BEAT_EN
  logic [EXT_W-1:0]  w_sum_full;
  logic [EXT_W-1:0]  w_diff_full;
  logic [DIFF_W-1:0] w_diff_trunc;
  logic [EXT_W-1:0]  w_diff_sext;

  assign w_sum_full   = w_a_ext + w_b_ext;
  assign w_diff_full  = w_a_ext - w_b_ext;
  assign w_diff_trunc = w_diff_full[DIFF_W-1:0];
  // Truncation is lossy when sign-extending the kept field does not restore a-b.
  assign w_diff_sext  = {{(EXT_W-DIFF_W){w_diff_trunc[DIFF_W-1]}}, w_diff_trunc};

  always_comb begin
    o_flags              = '0;
    o_flags[STAT_CARRY]  = (w_sum_full >> SUM_W) != '0;
    o_flags[STAT_BORROW] = i_a < i_b;
    o_flags[STAT_TRUNC]  = w_diff_sext != w_diff_full;
  end
`endif

endmodule

// File: rtl/addsub_pack_serializer.sv
// Latches an operand pair, packs {diff, sum} and streams it LSB-first in BEAT_W beats.
// Define ADDSUB_STATUS_BEAT_EN to append a carry/borrow/truncation status beat.
module addsub_pack_serializer
  import addsub_pack_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 8,
  parameter int unsigned DIFF_W = 4,
  parameter int unsigned BEAT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned PACK_W = DIFF_W + SUM_W;
  localparam int unsigned NBEATS = calc_nbeats(PACK_W, BEAT_W);
  localparam int unsigned PAD_W  = NBEATS * BEAT_W;
`ifdef ADDSUB_STATUS_BEAT_EN
  localparam int unsigned FRAME_BEATS = NBEATS + 1;
`else
  localparam int unsigned FRAME_BEATS = NBEATS;
`endif
  localparam int unsigned FRAME_W  = FRAME_BEATS * BEAT_W;
  localparam int unsigned IDX_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int unsigned LAST_IDX = FRAME_BEATS - 1;

`ifdef ADDSUB_STATUS_BEAT_EN
  if (BEAT_W < 3) begin : g_beat_w_check
    $error("addsub_pack_serializer: status beat needs BEAT_W >= 3");
  end
`endif

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] w_frame_nxt;
  logic [FRAME_W-1:0] w_frame_load;
  logic               r_out_valid;
  logic               w_valid_nxt;
  logic               r_out_last;
  logic               w_last_nxt;
  logic               w_beat_hs;
  logic               w_in_ready;
  logic               w_accept;
  logic [PACK_W-1:0]  w_packed;
  logic [PAD_W-1:0]   w_packed_pad;

`ifdef ADDSUB_STATUS_BEAT_EN
  logic [STAT_W-1:0]  w_flags;
`endif

  addsub_core #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W),
    .DIFF_W (DIFF_W)
  ) u_core (
    .i_a      (in_a),
    .i_b      (in_b),
`ifdef ADDSUB_STATUS_BEAT_EN
    .o_flags  (w_flags),
`endif
    .o_packed (w_packed)
  );

  // Frame image: data beats zero-padded on top, optional status beat above them.
  assign w_packed_pad = PAD_W'(w_packed);
`ifdef ADDSUB_STATUS_BEAT_EN
  assign w_frame_load = {BEAT_W'(w_flags), w_packed_pad};
`else
  assign w_frame_load = w_packed_pad;
`endif

  assign w_idx_inc = r_idx + IDX_W'(1);

  // Next-state logic; a last-beat handshake may reload the frame with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_frame_nxt = r_frame;
    w_valid_nxt = r_out_valid;
    w_last_nxt  = r_out_last;
    w_beat_hs   = r_out_valid & out_ready;
    w_in_ready  = (r_state == IDLE) | (w_beat_hs & r_out_last);
    w_accept    = in_valid & w_in_ready;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SEND;
          w_idx_nxt   = '0;
          w_frame_nxt = w_frame_load;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (FRAME_BEATS == 1);
        end
      end
      SEND: begin
        if (w_beat_hs) begin
          if (r_out_last) begin
            if (w_accept) begin
              w_idx_nxt   = '0;
              w_frame_nxt = w_frame_load;
              w_last_nxt  = (FRAME_BEATS == 1);
            end else begin
              w_state_nxt = IDLE;
              w_idx_nxt   = '0;
              w_frame_nxt = '0;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_frame_nxt = FRAME_W'(r_frame >> BEAT_W);
            w_last_nxt  = (w_idx_inc == IDX_W'(LAST_IDX));
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_frame     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame     <= w_frame_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_frame[BEAT_W-1:0];
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_addsub_pack_serializer.sv
// Directed self-checking bench for addsub_pack_serializer (default parameters).
module tb_addsub_pack_serializer;

`ifdef ADDSUB_STATUS_BEAT_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;

  int n_checks = 0;
  int n_errs   = 0;

  // Expected frames as nibbles LSB-first; top nibble is the status beat.
  logic [15:0] f_53 = 16'h0208;
  logic [15:0] f_35 = 16'h2E08;
  logic [15:0] f_ff = 16'h5D01;
  logic [15:0] f_80 = 16'h4080;

  addsub_pack_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the block idle; streams one frame with out_ready high.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    check_val("idle_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < FB; i++) begin
      check_val("beat_valid", out_valid, 1);
      check_val("beat_data", out_data, exp[i*4 +: 4]);
      check_val("beat_last", out_last, (i == FB-1));
      @(negedge clk);
    end
    check_val("frame_done", out_valid, 0);
  endtask

  initial begin
    logic [15:0] f1, f2;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_last", out_last, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    do_frame(8'h05, 8'h03, f_53);
    do_frame(8'h03, 8'h05, f_35);
    do_frame(8'hFF, 8'h02, f_ff);
    do_frame(8'h80, 8'h00, f_80);

    // Backpressure: hold first beat for 5 cycles, then drain.
    in_a = 8'h05; in_b = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", out_valid, 1);
      check_val("bp_data", out_data, 4'h8);
      check_val("bp_last", out_last, 0);
      check_val("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < FB; i++) begin
      check_val("bp_drain_data", out_data, f_53[i*4 +: 4]);
      check_val("bp_drain_last", out_last, (i == FB-1));
      @(negedge clk);
    end
    check_val("bp_done", out_valid, 0);

    // Back-to-back frames with in_valid held: no bubble between frames.
    f1 = f_53; f2 = f_35;
    in_a = 8'h05; in_b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_a = 8'h03; in_b = 8'h05;
    for (int i = 0; i < 2*FB; i++) begin
      logic [3:0] eb;
      eb = (i < FB) ? f1[i*4 +: 4] : f2[(i-FB)*4 +: 4];
      check_val("b2b_valid", out_valid, 1);
      check_val("b2b_data", out_data, eb);
      check_val("b2b_last", out_last, (i == FB-1) || (i == 2*FB-1));
      check_val("b2b_in_ready", in_ready, (i == FB-1) || (i == 2*FB-1));
      if (i == FB) in_valid = 1'b0;
      @(negedge clk);
    end
    check_val("b2b_done", out_valid, 0);

    // Async reset while the last data beat is presented.
    in_a = 8'h05; in_b = 8'h03; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("pre_rst_data", out_data, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", out_valid, 0);
    check_val("arst_last", out_last, 0);
    check_val("arst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", in_ready, 1);
    check_val("post_rst_valid", out_valid, 0);
    do_frame(8'h03, 8'h05, f_35);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
